// File: rtl/melody_sequencer.sv
// Data-driven melody player: fetches {note, duration} words from a registered song ROM and drives a square-wave speaker.
// Optional MELODY_SEQ_LOOP_EN: the end marker restarts playback at address 0 instead of returning to idle.
module melody_sequencer #(
  parameter int CLK_HZ   = 25000000,
  parameter int TICK_DIV = 2500000,
  parameter int ADDR_W   = 7,
  parameter int HP_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        note_code,
  output logic              spk,
  output logic              busy,
  output logic              done
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int FREQ_HZ [0:7] = '{0, 262, 294, 330, 349, 392, 440, 494};

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, END} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [3:0]        note_reg, note_next;
  logic              spk_reg, spk_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [4:0]        dur_reg, dur_next;
  logic [PRE_W-1:0]  pre_reg, pre_next;
  logic [HP_W-1:0]   tone_reg, tone_next;
  logic [HP_W-1:0]   hp_reg, hp_next;
  logic              tone_en_reg, tone_en_next;
  logic [HP_W-1:0]   hp_table [0:7];
  logic              tick;
  logic [3:0]        rom_code;

  // Half-period table, one constant per scale note; entry 0 is never used for tone.
  assign hp_table[0] = '0;
  for (genvar gi = 1; gi < 8; gi++) begin : g_hp
    assign hp_table[gi] = HP_W'(CLK_HZ / FREQ_HZ[gi] / 2);
  end

  assign tick     = (pre_reg == PRE_W'(TICK_DIV - 1));
  assign rom_code = rom_data[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      note_reg    <= '0;
      spk_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dur_reg     <= '0;
      pre_reg     <= '0;
      tone_reg    <= '0;
      hp_reg      <= '0;
      tone_en_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      note_reg    <= note_next;
      spk_reg     <= spk_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      dur_reg     <= dur_next;
      pre_reg     <= pre_next;
      tone_reg    <= tone_next;
      hp_reg      <= hp_next;
      tone_en_reg <= tone_en_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    note_next    = note_reg;
    spk_next     = 1'b0;
    done_next    = 1'b0;
    dur_next     = dur_reg;
    pre_next     = pre_reg;
    tone_next    = tone_reg;
    hp_next      = hp_reg;
    tone_en_next = tone_en_reg;

    unique case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          addr_next  = '0;
          state_next = FETCH;
        end
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        if (rom_code == 4'hF) begin
          done_next = 1'b1;
`ifdef MELODY_SEQ_LOOP_EN
          addr_next  = '0;
          state_next = FETCH;
`else
          state_next = END;
`endif
        end else begin
          note_next    = rom_code;
          dur_next     = (rom_data[3:0] == 4'd0) ? 5'd16 : {1'b0, rom_data[3:0]};
          pre_next     = '0;
          tone_en_next = (rom_code != 4'd0) && !rom_code[3];
          hp_next      = hp_table[rom_code[2:0]];
          tone_next    = hp_table[rom_code[2:0]] - HP_W'(1);
          state_next   = PLAY;
        end
      end
      PLAY: begin
        if (tone_en_reg) begin
          if (tone_reg == '0) begin
            tone_next = hp_reg - HP_W'(1);
            spk_next  = !spk_reg;
          end else begin
            tone_next = tone_reg - HP_W'(1);
            spk_next  = spk_reg;
          end
        end
        if (tick) begin
          pre_next = '0;
          dur_next = dur_reg - 5'd1;
          // Last beat of this note: silence and advance (address wraps naturally).
          if (dur_reg == 5'd1) begin
            addr_next  = addr_reg + ADDR_W'(1);
            note_next  = '0;
            spk_next   = 1'b0;
            state_next = FETCH;
          end
        end else begin
          pre_next = pre_reg + PRE_W'(1);
        end
      end
      END: begin
        addr_next  = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (stop && state_reg != IDLE) begin
      state_next = IDLE;
      addr_next  = '0;
      note_next  = '0;
      spk_next   = 1'b0;
      done_next  = 1'b0;
    end

    busy_next = (state_next != IDLE);
  end

  assign rom_addr  = addr_reg;
  assign note_code = note_reg;
  assign spk       = spk_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
